updown_counter60: RTL

UPDOWN_COUNTER60 -- requirements
Module: updown_counter60

---
 rtl/updown_counter60.sv | 96 +++++++++
 1 files changed

// File: rtl/updown_counter60.sv
// Two-digit BCD up/down counter (ones 0..9, tens 0..TENS_MOD-1) with load, clear and cascade outputs.
// Define UPDOWN_COUNTER60_RIPPLE_EN to qualify CO/BO with EN for clean multi-stage chaining.
module updown_counter60 #(
  parameter int TENS_MOD = 6
) (
  input  logic       CP,
  input  logic       CLR,
  input  logic       EN,
  input  logic       U,
  input  logic       LD,
  input  logic [3:0] D_ONES,
  input  logic [2:0] D_TENS,
  output logic [3:0] Q_ONES,
  output logic [2:0] Q_TENS,
  output logic       CO,
  output logic       BO
);

  localparam logic [2:0] TENS_MAX = 3'(TENS_MOD - 1);
  localparam logic [3:0] TENS_LIM = 4'(TENS_MOD);

  logic [3:0] r_ones;
  logic [2:0] r_tens;

  logic [3:0] w_ones_next;
  logic [2:0] w_tens_next;
  logic [3:0] w_ld_ones;
  logic [2:0] w_ld_tens;
  logic       w_state_ok;
  logic       w_at_max;
  logic       w_at_zero;
  logic       w_co_term;
  logic       w_bo_term;

  // Each load digit is validated independently; a bad digit becomes 0 without touching the other.
  assign w_ld_ones = (D_ONES <= 4'd9) ? D_ONES : 4'd0;
  assign w_ld_tens = ({1'b0, D_TENS} < TENS_LIM) ? D_TENS : 3'd0;

  assign w_state_ok = (r_ones <= 4'd9) && ({1'b0, r_tens} < TENS_LIM);
  assign w_at_max   = w_state_ok && (r_ones == 4'd9) && (r_tens == TENS_MAX);
  assign w_at_zero  = (r_ones == 4'd0) && (r_tens == 3'd0);

  always_comb begin
    w_ones_next = r_ones;
    w_tens_next = r_tens;
    if (LD) begin
      w_ones_next = w_ld_ones;
      w_tens_next = w_ld_tens;
    end else if (EN) begin
      if (!w_state_ok) begin
        // Corrupted state falls back to 00 rather than counting from garbage.
        w_ones_next = 4'd0;
        w_tens_next = 3'd0;
      end else if (U) begin
        if (r_ones == 4'd9) begin
          w_ones_next = 4'd0;
          w_tens_next = (r_tens == TENS_MAX) ? 3'd0 : r_tens + 3'd1;
        end else begin
          w_ones_next = r_ones + 4'd1;
        end
      end else begin
        if (r_ones == 4'd0) begin
          w_ones_next = 4'd9;
          w_tens_next = (r_tens == 3'd0) ? TENS_MAX : r_tens - 3'd1;
        end else begin
          w_ones_next = r_ones - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge CP) begin
    if (CLR) begin
      r_ones <= 4'd0;
      r_tens <= 3'd0;
    end else begin
      r_ones <= w_ones_next;
      r_tens <= w_tens_next;
    end
  end

  assign w_co_term = U && w_at_max && !CLR;
  assign w_bo_term = !U && w_at_zero && !CLR;

`ifdef UPDOWN_COUNTER60_RIPPLE_EN
  assign CO = w_co_term && EN;
  assign BO = w_bo_term && EN;
`else
  assign CO = w_co_term;
  assign BO = w_bo_term;
`endif

  assign Q_ONES = r_ones;
  assign Q_TENS = r_tens;

endmodule
